// File: rtl/chip8_mem_arbiter_if.sv
// Bus bundle between the CHIP-8 RAM arbiter and its requesters/RAM.
//   cpu_*  : CPU fetch/data port (req/we/addr/wdata in, ack/rvalid/rdata out)
//   drw_*  : sprite draw engine port, same shape as cpu_*
//   vid_*  : video scanout read-only port (req/addr in, ack/rvalid/rdata out)
//   mem_*  : single-port synchronous RAM, 1-cycle read latency
// slave  : arbiter view.  master : requester/RAM environment view.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              drw_req;
  logic              drw_we;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] drw_wdata;
  logic              drw_ack;
  logic              drw_rvalid;
  logic [DATA_W-1:0] drw_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    input  drw_req, drw_we, drw_addr, drw_wdata,
    output drw_ack, drw_rvalid, drw_rdata,
    input  vid_req, vid_addr,
    output vid_ack, vid_rvalid, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    output drw_req, drw_we, drw_addr, drw_wdata,
    input  drw_ack, drw_rvalid, drw_rdata,
    output vid_req, vid_addr,
    input  vid_ack, vid_rvalid, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Shares the single-port CHIP-8 RAM between CPU, draw engine and video.
// One RAM access per clock. Video has fixed priority, bounded by VID_BURST
// consecutive grants while CPU/draw wait; CPU and draw alternate round-robin.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : chip8_mem_arbiter_if.slave (requester ports + RAM port)
// Grants are registered: ack/mem_* appear after the sampling edge, the read
// data and its rvalid one edge later.
module chip8_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int VID_BURST = 4
) (
  input logic                 clk,
  input logic                 reset,
  chip8_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_DRW  = 2'd2,
    SRC_VID  = 2'd3
  } src_e;

  typedef enum logic {
    RR_CPU = 1'b0,
    RR_DRW = 1'b1
  } rr_e;

  localparam logic [3:0] BURST_MAX = 4'(VID_BURST);

  logic              cpu_elig;
  logic              drw_elig;
  logic              vid_elig;
  logic              side_elig;
  logic              vid_capped;
  src_e              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  src_e              rd_tag;
  rr_e               rr_ptr;
  logic [3:0]        burst_cnt;

  // A requester whose ack is high this cycle is masked, so a req still held
  // during its ack cycle is never granted a second time.
  always_comb begin
    cpu_elig   = bus.cpu_req & ~bus.cpu_ack;
    drw_elig   = bus.drw_req & ~bus.drw_ack;
    vid_elig   = bus.vid_req & ~bus.vid_ack;
    side_elig  = cpu_elig | drw_elig;
    vid_capped = (burst_cnt == BURST_MAX) && side_elig;

    win = SRC_NONE;
    if (vid_elig && !vid_capped) begin
      win = SRC_VID;
    end else if (cpu_elig && drw_elig) begin
      win = (rr_ptr == RR_CPU) ? SRC_CPU : SRC_DRW;
    end else if (cpu_elig) begin
      win = SRC_CPU;
    end else if (drw_elig) begin
      win = SRC_DRW;
    end
  end

  // Address/data of the winner; with no winner (or video, which has no
  // write data) the RAM-side registers keep their previous contents.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = bus.mem_addr;
    win_wdata = bus.mem_wdata;
    case (win)
      SRC_CPU: begin
        win_we    = bus.cpu_we;
        win_addr  = bus.cpu_addr;
        win_wdata = bus.cpu_wdata;
      end
      SRC_DRW: begin
        win_we    = bus.drw_we;
        win_addr  = bus.drw_addr;
        win_wdata = bus.drw_wdata;
      end
      SRC_VID: begin
        win_addr  = bus.vid_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cpu_ack    <= 1'b0;
      bus.drw_ack    <= 1'b0;
      bus.vid_ack    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.drw_rvalid <= 1'b0;
      bus.vid_rvalid <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      rd_tag         <= SRC_NONE;
      rr_ptr         <= RR_CPU;
      burst_cnt      <= '0;
    end else begin
      bus.cpu_ack   <= (win == SRC_CPU);
      bus.drw_ack   <= (win == SRC_DRW);
      bus.vid_ack   <= (win == SRC_VID);
      bus.mem_en    <= (win != SRC_NONE);
      bus.mem_we    <= win_we;
      bus.mem_addr  <= win_addr;
      bus.mem_wdata <= win_wdata;

      // Tag travels alongside mem_en; its shifted copy marks the cycle in
      // which mem_rdata carries the owner's data.
      rd_tag         <= (win != SRC_NONE && !win_we) ? win : SRC_NONE;
      bus.cpu_rvalid <= (rd_tag == SRC_CPU);
      bus.drw_rvalid <= (rd_tag == SRC_DRW);
      bus.vid_rvalid <= (rd_tag == SRC_VID);

      // Pointer only moves when CPU and draw actually contended.
      if (cpu_elig && drw_elig && (win == SRC_CPU || win == SRC_DRW)) begin
        rr_ptr <= (win == SRC_CPU) ? RR_DRW : RR_CPU;
      end

      if (win == SRC_VID) begin
        if (side_elig && burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.drw_rdata = bus.mem_rdata;
  assign bus.vid_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: directed scenarios followed by
// randomized traffic. A reference model predicts each cycle's grant and each
// read return; a monitor compares DUT outputs against the queued predictions.
module tb_chip8_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int VB = 4;
  localparam int NONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  chip8_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VID_BURST(VB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    if (a == 32'h200) return 8'hA2;
    return 8'((a * 13 + 7) ^ (a >> 5));
  endfunction

  // Synchronous RAM, 1-cycle read latency
  logic [7:0] ram [4096];
  logic [7:0] ram_q = 8'h00;
  logic       ram_loaded = 1'b0;
  assign bus.mem_rdata = ram_q;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_byte(a);
      ram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end

  // Reference model: requester index 0=cpu, 1=drw, 2=vid, 3=none
  typedef struct {
    int         who;
    logic       we;
    logic [11:0] addr;
    logic [7:0]  wd;
  } gnt_t;

  typedef struct {
    int         who;
    logic [7:0] data;
    int         due;
  } rd_t;

  gnt_t gq[$];
  rd_t  rdq[$];

  logic [7:0]  mmem [4096];
  bit          m_loaded = 1'b0;
  bit          m_ack [3];
  bit          m_el [3];
  bit          m_side;
  int          m_ptr;
  int          m_burst;
  int          m_w;
  int          cyc = 0;
  logic [11:0] m_addr;
  logic [7:0]  m_wd;
  gnt_t        m_g;
  rd_t         m_r;

  always @(posedge clk or negedge reset) begin
    if (!m_loaded) begin
      for (int a = 0; a < 4096; a++) mmem[a] = init_byte(a);
      m_loaded = 1'b1;
    end
    if (!reset) begin
      m_ack   = '{0, 0, 0};
      m_ptr   = 0;
      m_burst = 0;
      m_addr  = '0;
      m_wd    = '0;
      gq.delete();
      rdq.delete();
    end else begin
      m_el[0] = bus.cpu_req && !m_ack[0];
      m_el[1] = bus.drw_req && !m_ack[1];
      m_el[2] = bus.vid_req && !m_ack[2];
      m_side  = m_el[0] || m_el[1];
      m_w = NONE;
      if (m_el[2] && !(m_burst == VB && m_side)) m_w = 2;
      else if (m_el[0] && m_el[1]) begin
        m_w = m_ptr;
        m_ptr = 1 - m_ptr;
      end else if (m_el[0]) m_w = 0;
      else if (m_el[1]) m_w = 1;

      if (m_w == 2) begin
        if (m_side && m_burst < VB) m_burst++;
      end else begin
        m_burst = 0;
      end

      cyc++;
      for (int i = 0; i < 3; i++) m_ack[i] = (m_w == i);

      m_g.who = m_w;
      m_g.we  = 1'b0;
      case (m_w)
        0: begin m_g.we = bus.cpu_we; m_addr = bus.cpu_addr; m_wd = bus.cpu_wdata; end
        1: begin m_g.we = bus.drw_we; m_addr = bus.drw_addr; m_wd = bus.drw_wdata; end
        2: begin m_addr = bus.vid_addr; end
        default: ;
      endcase
      m_g.addr = m_addr;
      m_g.wd   = m_wd;
      gq.push_back(m_g);

      if (m_w != NONE) begin
        if (m_g.we) mmem[m_addr] = m_wd;
        else begin
          m_r.who  = m_w;
          m_r.data = mmem[m_addr];
          m_r.due  = cyc + 1;
          rdq.push_back(m_r);
        end
      end
    end
  end

  // Monitor
  gnt_t        mon_e;
  rd_t         mon_r;
  logic [2:0]  mon_rv;
  logic [7:0]  mon_d;

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs",
            {bus.cpu_ack, bus.drw_ack, bus.vid_ack, bus.cpu_rvalid, bus.drw_rvalid,
             bus.vid_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    end else begin
      if (gq.size() > 0) begin
        mon_e = gq.pop_front();
        check("ack", {bus.vid_ack, bus.drw_ack, bus.cpu_ack},
              (mon_e.who == NONE) ? 0 : (1 << mon_e.who));
        check("mem_en", bus.mem_en, mon_e.who != NONE);
        check("mem_we", bus.mem_we, mon_e.we);
        check("mem_addr", bus.mem_addr, mon_e.addr);
        check("mem_wdata", bus.mem_wdata, mon_e.wd);
      end
      mon_rv = 3'b000;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        mon_r  = rdq.pop_front();
        mon_rv = 3'(1 << mon_r.who);
        case (mon_r.who)
          0:       mon_d = bus.cpu_rdata;
          1:       mon_d = bus.drw_rdata;
          default: mon_d = bus.vid_rdata;
        endcase
        check("rdata", mon_d, mon_r.data);
      end
      check("rvalid", {bus.vid_rvalid, bus.drw_rvalid, bus.cpu_rvalid}, mon_rv);
    end
  end

  // Stimulus
  bit          rq_req [3];
  bit          rq_we [3];
  logic [11:0] rq_addr [3];
  logic [7:0]  rq_wd [3];
  int          p_new [3];
  int          p_cancel [3];
  bit          rd_only;

  task automatic apply();
    bus.cpu_req   = rq_req[0];
    bus.cpu_we    = rq_we[0];
    bus.cpu_addr  = rq_addr[0];
    bus.cpu_wdata = rq_wd[0];
    bus.drw_req   = rq_req[1];
    bus.drw_we    = rq_we[1];
    bus.drw_addr  = rq_addr[1];
    bus.drw_wdata = rq_wd[1];
    bus.vid_req   = rq_req[2];
    bus.vid_addr  = rq_addr[2];
  endtask

  task automatic set_req(input int i, input bit we, input logic [11:0] a, input logic [7:0] d);
    rq_req[i]  = 1'b1;
    rq_we[i]   = we;
    rq_addr[i] = a;
    rq_wd[i]   = d;
    apply();
  endtask

  task automatic new_req(input int i);
    rq_req[i]  = 1'b1;
    rq_we[i]   = (i != 2) && !rd_only && ($urandom_range(0, 2) == 0);
    // Half the traffic hits a small window straddling the address wrap
    rq_addr[i] = ($urandom_range(0, 1) == 1) ? 12'(12'hFF8 + $urandom_range(0, 15))
                                               : 12'($urandom);
    rq_wd[i]   = 8'($urandom);
  endtask

  function automatic bit ack_of(input int i);
    case (i)
      0:       return bus.cpu_ack;
      1:       return bus.drw_ack;
      default: return bus.vid_ack;
    endcase
  endfunction

  task automatic agent_step();
    for (int i = 0; i < 3; i++) begin
      if (rq_req[i] && ack_of(i)) begin
        if (int'($urandom_range(0, 99)) < p_new[i]) new_req(i);
        else rq_req[i] = 1'b0;
      end else if (rq_req[i]) begin
        if (int'($urandom_range(0, 99)) < p_cancel[i]) rq_req[i] = 1'b0;
      end else if (int'($urandom_range(0, 99)) < p_new[i]) begin
        new_req(i);
      end
    end
    apply();
  endtask

  task automatic run_agents(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      agent_step();
    end
  endtask

  task automatic set_probs(input int c, input int d, input int v, input int cancel);
    p_new[0] = c; p_new[1] = d; p_new[2] = v;
    for (int i = 0; i < 3; i++) p_cancel[i] = cancel;
  endtask

  task automatic quiesce();
    set_probs(0, 0, 0, 0);
    run_agents(10);
  endtask

  task automatic wait_ack(input int i);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ack_of(i)) seen = 1'b1;
    end
    check("ack_seen", seen, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rq_req[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wd[i] = '0;
    end
    set_probs(0, 0, 0, 0);
    rd_only = 1'b0;
    apply();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Single CPU read of 0x200, req held through the ack cycle
    @(negedge clk);
    set_req(0, 1'b0, 12'h200, 8'h00);
    wait_ack(0);
    @(negedge clk);
    rq_req[0] = 1'b0; apply();
    repeat (3) @(negedge clk);

    // CPU write 0x5C -> 0x300, then draw reads it back
    set_req(0, 1'b1, 12'h300, 8'h5C);
    wait_ack(0);
    rq_req[0] = 1'b0; apply();
    set_req(1, 1'b0, 12'h300, 8'h00);
    wait_ack(1);
    rq_req[1] = 1'b0; apply();
    repeat (3) @(negedge clk);

    // CPU and draw both streaming reads
    rd_only = 1'b1;
    set_probs(100, 100, 0, 0);
    run_agents(30);
    quiesce();

    // Video streaming alongside CPU
    set_probs(100, 0, 100, 0);
    run_agents(30);
    quiesce();

    // Video alone
    set_probs(0, 0, 100, 0);
    run_agents(20);
    quiesce();

    // Reset during the ack cycle of a video read
    @(negedge clk);
    set_req(2, 1'b0, 12'h123, 8'h00);
    wait_ack(2);
    #2 reset = 1'b0;
    #1 check("reset_immediate",
             {bus.cpu_ack, bus.drw_ack, bus.vid_ack, bus.cpu_rvalid, bus.drw_rvalid,
              bus.vid_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    rq_req[2] = 1'b0; apply();
    repeat (2) @(negedge clk);
    set_req(0, 1'b0, 12'h040, 8'h00);
    set_req(1, 1'b0, 12'h041, 8'h00);
    #2 reset = 1'b1;
    wait_ack(0);
    check("first_after_reset_drw_ack", bus.drw_ack, 1'b0);
    rq_req[0] = 1'b0; apply();
    wait_ack(1);
    rq_req[1] = 1'b0; apply();
    quiesce();

    // Randomized mixed traffic with cancellations
    rd_only = 1'b0;
    set_probs(35, 35, 45, 6);
    run_agents(3000);
    set_probs(0, 0, 0, 100);
    run_agents(2);
    quiesce();

    check("reads_outstanding", rdq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
